alu_op_sequencer: RTL and testbench

//  Sequences one ALU operation per request: decodes a 5-bit opcode into the ALU's one-hot strobes, drives operands A/B,

---
 rtl/alu_seq_pkg.sv | 58 +++++
 rtl/alu_op_decode.sv | 37 +++
 rtl/alu_op_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, ALU strobe bit positions, FSM encoding and decode payload
// for the ALU operation sequencer.
package alu_seq_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 15;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

    // Strobe positions inside alu_ctrl; bits 13 and 14 are spare and stay 0.
    localparam int unsigned CTRL_ADD  = 0;
    localparam int unsigned CTRL_SUB  = 1;
    localparam int unsigned CTRL_MUL  = 2;
    localparam int unsigned CTRL_DIV  = 3;
    localparam int unsigned CTRL_SHR  = 4;
    localparam int unsigned CTRL_SHRA = 5;
    localparam int unsigned CTRL_SHL  = 6;
    localparam int unsigned CTRL_ROR  = 7;
    localparam int unsigned CTRL_ROL  = 8;
    localparam int unsigned CTRL_AND  = 9;
    localparam int unsigned CTRL_OR   = 10;
    localparam int unsigned CTRL_NEG  = 11;
    localparam int unsigned CTRL_NOT  = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic              is_muldiv;
        logic              is_div;
        logic              legal;
    } dec_t;

    function automatic logic [CTRL_W-1:0] ctrl_bit(input int unsigned idx);
        return CTRL_W'(1) << idx;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode into one-hot ALU strobes plus class flags.
module alu_op_decode
    import alu_seq_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    output dec_t            o_dec
);

    always_comb begin
        o_dec       = '0;
        o_dec.legal = 1'b1;
        case (i_op)
            OP_ADD, OP_ADDI: o_dec.ctrl = ctrl_bit(CTRL_ADD);
            OP_SUB:          o_dec.ctrl = ctrl_bit(CTRL_SUB);
            OP_AND, OP_ANDI: o_dec.ctrl = ctrl_bit(CTRL_AND);
            OP_OR,  OP_ORI:  o_dec.ctrl = ctrl_bit(CTRL_OR);
            OP_ROR:          o_dec.ctrl = ctrl_bit(CTRL_ROR);
            OP_ROL:          o_dec.ctrl = ctrl_bit(CTRL_ROL);
            OP_SHR:          o_dec.ctrl = ctrl_bit(CTRL_SHR);
            OP_SHRA:         o_dec.ctrl = ctrl_bit(CTRL_SHRA);
            OP_SHL:          o_dec.ctrl = ctrl_bit(CTRL_SHL);
            OP_NEG:          o_dec.ctrl = ctrl_bit(CTRL_NEG);
            OP_NOT:          o_dec.ctrl = ctrl_bit(CTRL_NOT);
            OP_MUL: begin
                o_dec.ctrl      = ctrl_bit(CTRL_MUL);
                o_dec.is_muldiv = 1'b1;
            end
            OP_DIV: begin
                o_dec.ctrl      = ctrl_bit(CTRL_DIV);
                o_dec.is_muldiv = 1'b1;
                o_dec.is_div    = 1'b1;
            end
            default:         o_dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Runs one ALU operation per accepted request: drives operands and strobe for
// the op's settle time, then captures the 64-bit result until it is consumed.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [63:0]       alu_c,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] z_hi,
    output logic [DATA_W-1:0] z_lo,
    output logic              hi_we,
    output logic              lo_we,
    output logic              div_by_zero,
    output logic              illegal_op
);

    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_alu_a, w_alu_a_nxt;
    logic [DATA_W-1:0]   r_alu_b, w_alu_b_nxt;
    logic [CTRL_W-1:0]   r_alu_ctrl, w_alu_ctrl_nxt;
    logic [DATA_W-1:0]   r_z_hi, w_z_hi_nxt;
    logic [DATA_W-1:0]   r_z_lo, w_z_lo_nxt;
    logic                r_req_ready, w_req_ready_nxt;
    logic                r_resp_valid, w_resp_valid_nxt;
    logic                r_muldiv, w_muldiv_nxt;
    logic                r_legal, w_legal_nxt;
    logic                r_dbz, w_dbz_nxt;
    logic                r_illegal, w_illegal_nxt;
    dec_t                w_dec;

    alu_op_decode u_decode (
        .i_op  (req_op),
        .o_dec (w_dec)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= '0;
            r_z_hi       <= '0;
            r_z_lo       <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_muldiv     <= 1'b0;
            r_legal      <= 1'b0;
            r_dbz        <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_alu_a      <= w_alu_a_nxt;
            r_alu_b      <= w_alu_b_nxt;
            r_alu_ctrl   <= w_alu_ctrl_nxt;
            r_z_hi       <= w_z_hi_nxt;
            r_z_lo       <= w_z_lo_nxt;
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_muldiv     <= w_muldiv_nxt;
            r_legal      <= w_legal_nxt;
            r_dbz        <= w_dbz_nxt;
            r_illegal    <= w_illegal_nxt;
        end
    end

    // Next-state and next-output logic; operands/strobe live only while in EXEC.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_alu_a_nxt      = r_alu_a;
        w_alu_b_nxt      = r_alu_b;
        w_alu_ctrl_nxt   = r_alu_ctrl;
        w_z_hi_nxt       = r_z_hi;
        w_z_lo_nxt       = r_z_lo;
        w_req_ready_nxt  = r_req_ready;
        w_resp_valid_nxt = r_resp_valid;
        w_muldiv_nxt     = r_muldiv;
        w_legal_nxt      = r_legal;
        w_dbz_nxt        = r_dbz;
        w_illegal_nxt    = r_illegal;

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt     = ST_EXEC;
                    w_req_ready_nxt = 1'b0;
                    w_alu_a_nxt     = req_a;
                    w_alu_b_nxt     = req_b;
                    w_alu_ctrl_nxt  = w_dec.ctrl;
                    w_muldiv_nxt    = w_dec.is_muldiv;
                    w_legal_nxt     = w_dec.legal;
                    w_dbz_nxt       = w_dec.is_div && (req_b == '0);
                    w_illegal_nxt   = 1'b0;
                    if (w_dec.is_div)
                        w_cnt_nxt = CNT_W'(DIV_CYCLES - 1);
                    else if (w_dec.is_muldiv)
                        w_cnt_nxt = CNT_W'(MUL_CYCLES - 1);
                    else
                        w_cnt_nxt = '0;
                end
            end
            ST_EXEC: begin
                if (r_cnt == '0) begin
                    w_state_nxt      = ST_DONE;
                    w_resp_valid_nxt = 1'b1;
                    w_alu_a_nxt      = '0;
                    w_alu_b_nxt      = '0;
                    w_alu_ctrl_nxt   = '0;
                    w_illegal_nxt    = !r_legal;
                    // Illegal ops never strobe the ALU, so whatever it drives is discarded.
                    w_z_hi_nxt       = r_legal ? alu_c[63:32] : '0;
                    w_z_lo_nxt       = r_legal ? alu_c[31:0]  : '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    w_state_nxt      = ST_IDLE;
                    w_resp_valid_nxt = 1'b0;
                    w_req_ready_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_req_ready_nxt  = 1'b1;
                w_resp_valid_nxt = 1'b0;
                w_alu_a_nxt      = '0;
                w_alu_b_nxt      = '0;
                w_alu_ctrl_nxt   = '0;
            end
        endcase
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_ctrl    = r_alu_ctrl;
    assign z_hi        = r_z_hi;
    assign z_lo        = r_z_lo;
    assign div_by_zero = r_dbz;
    assign illegal_op  = r_illegal;

    // HI/LO write pulse coincides with the response handshake itself.
    assign hi_we = r_resp_valid && resp_ready && r_muldiv && !r_dbz;
    assign lo_we = hi_we;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU on alu_c.
module tb_alu_op_sequencer;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [14:0] alu_ctrl;
    logic [63:0] alu_c;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        hi_we;
    logic        lo_we;
    logic        div_by_zero;
    logic        illegal_op;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    alu_op_sequencer #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_c       (alu_c),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .z_hi        (z_hi),
        .z_lo        (z_lo),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    // Behavioural ALU; drives a junk pattern when no strobe is active.
    logic [5:0]  m_sh;
    logic [31:0] m_sra;
    always_comb begin
        m_sh  = {1'b0, alu_b[4:0]};
        m_sra = $signed(alu_a) >>> m_sh;
        alu_c = 64'hDEADBEEF_CAFEF00D;
        case (alu_ctrl)
            15'h0001: alu_c = {32'd0, alu_a + alu_b};
            15'h0002: alu_c = {32'd0, alu_a - alu_b};
            15'h0004: alu_c = {32'd0, alu_a} * {32'd0, alu_b};
            15'h0008: alu_c = (alu_b == 32'd0) ? 64'hFFFFFFFF_FFFFFFFF : {alu_a % alu_b, alu_a / alu_b};
            15'h0010: alu_c = {32'd0, alu_a >> m_sh};
            15'h0020: alu_c = {32'd0, m_sra};
            15'h0040: alu_c = {32'd0, alu_a << m_sh};
            15'h0080: alu_c = {32'd0, (alu_a >> m_sh) | (alu_a << (6'd32 - m_sh))};
            15'h0100: alu_c = {32'd0, (alu_a << m_sh) | (alu_a >> (6'd32 - m_sh))};
            15'h0200: alu_c = {32'd0, alu_a & alu_b};
            15'h0400: alu_c = {32'd0, alu_a | alu_b};
            15'h0800: alu_c = {32'd0, 32'd0 - alu_a};
            15'h1000: alu_c = {32'd0, ~alu_a};
            default:  alu_c = 64'hDEADBEEF_CAFEF00D;
        endcase
    end

    // Accept one request and wait (bounded) for resp_valid; lat=-1 on timeout.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [14:0] ctrl_or, output logic onehot_ok);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_a     = 32'h5A5A5A5A;
        req_b     = 32'h0;
        lat       = 0;
        ctrl_or   = '0;
        onehot_ok = 1'b1;
        while (!resp_valid && lat >= 0) begin
            ctrl_or = ctrl_or | alu_ctrl;
            if (alu_ctrl != 15'd0 && $countones(alu_ctrl) != 1) onehot_ok = 1'b0;
            @(posedge clock); #1;
            lat++;
            if (lat > 40) lat = -1;
        end
        if (alu_ctrl != 15'd0) onehot_ok = 1'b0;
    endtask

    task automatic test_reset();
        clear_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        total++; if ({resp_valid, hi_we, lo_we, div_by_zero, illegal_op} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {resp_valid, hi_we, lo_we, div_by_zero, illegal_op}); end
        total++; if ({alu_a, alu_b, alu_ctrl, z_hi, z_lo} !== '0) begin bad++; $display("FAIL reset_data got=%h %h %h %h %h exp=0", alu_a, alu_b, alu_ctrl, z_hi, z_lo); end
        clear_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_add();
        int lat; logic [14:0] c; logic oh;
        resp_ready = 1'b1;
        issue(5'b00011, 32'd5, 32'd7, lat, c, oh);
        total++; if (lat !== 1) begin bad++; $display("FAIL add_latency got=%0d exp=1", lat); end
        total++; if (z_lo !== 32'd12) begin bad++; $display("FAIL add_z_lo got=%h exp=0000000c", z_lo); end
        total++; if (z_hi !== 32'd0) begin bad++; $display("FAIL add_z_hi got=%h exp=0", z_hi); end
        total++; if (c !== 15'h0001) begin bad++; $display("FAIL add_ctrl got=%h exp=0001", c); end
        total++; if ({hi_we, lo_we} !== 2'b00) begin bad++; $display("FAIL add_we got=%b exp=00", {hi_we, lo_we}); end
        @(posedge clock); #1;
        resp_ready = 1'b0;
        total++; if ({req_ready, resp_valid} !== 2'b10) begin bad++; $display("FAIL add_back_idle got=%b exp=10", {req_ready, resp_valid}); end
    endtask

    task automatic test_mul();
        int lat; logic [14:0] c; logic oh;
        issue(5'b10000, 32'h0001_0000, 32'h0001_0000, lat, c, oh);
        total++; if (lat !== 2) begin bad++; $display("FAIL mul_latency got=%0d exp=2", lat); end
        total++; if ({z_hi, z_lo} !== 64'h00000001_00000000) begin bad++; $display("FAIL mul_z got=%h_%h exp=00000001_00000000", z_hi, z_lo); end
        total++; if (c !== 15'h0004) begin bad++; $display("FAIL mul_ctrl got=%h exp=0004", c); end
        total++; if ({hi_we, lo_we} !== 2'b00) begin bad++; $display("FAIL mul_we_early got=%b exp=00", {hi_we, lo_we}); end
        resp_ready = 1'b1; #1;
        total++; if ({hi_we, lo_we} !== 2'b11) begin bad++; $display("FAIL mul_we_pulse got=%b exp=11", {hi_we, lo_we}); end
        @(posedge clock); #1;
        total++; if ({hi_we, lo_we, resp_valid, req_ready} !== 4'b0001) begin bad++; $display("FAIL mul_after_hs got=%b exp=0001", {hi_we, lo_we, resp_valid, req_ready}); end
        resp_ready = 1'b0;
    endtask

    task automatic test_div();
        int lat; logic [14:0] c; logic oh;
        issue(5'b01111, 32'd17, 32'd5, lat, c, oh);
        total++; if (lat !== 4) begin bad++; $display("FAIL div_latency got=%0d exp=4", lat); end
        total++; if ({z_hi, z_lo} !== {32'd2, 32'd3}) begin bad++; $display("FAIL div_z got=%h_%h exp=00000002_00000003", z_hi, z_lo); end
        total++; if ({c, div_by_zero, oh} !== {15'h0008, 1'b0, 1'b1}) begin bad++; $display("FAIL div_ctrl got=%h dbz=%b oh=%b exp=0008 0 1", c, div_by_zero, oh); end
        resp_ready = 1'b1; #1;
        total++; if ({hi_we, lo_we} !== 2'b11) begin bad++; $display("FAIL div_we got=%b exp=11", {hi_we, lo_we}); end
        @(posedge clock); #1;
        resp_ready = 1'b0;
        issue(5'b01111, 32'd9, 32'd0, lat, c, oh);
        total++; if (lat !== 4) begin bad++; $display("FAIL dbz_latency got=%0d exp=4", lat); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
        total++; if ({z_hi, z_lo} !== 64'hFFFFFFFF_FFFFFFFF) begin bad++; $display("FAIL dbz_z got=%h_%h exp=ffffffff_ffffffff", z_hi, z_lo); end
        resp_ready = 1'b1; #1;
        total++; if ({hi_we, lo_we} !== 2'b00) begin bad++; $display("FAIL dbz_we got=%b exp=00", {hi_we, lo_we}); end
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat; logic [14:0] c; logic oh;
        issue(5'b00100, 32'd3, 32'd5, lat, c, oh);
        total++; if (lat !== 1) begin bad++; $display("FAIL sub_latency got=%0d exp=1", lat); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL sub_dbz_cleared got=%b exp=0", div_by_zero); end
        // A competing request while busy must be ignored.
        req_valid = 1'b1; req_op = 5'b00011; req_a = 32'd1; req_b = 32'd2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            total++; if ({resp_valid, req_ready, z_lo} !== {1'b1, 1'b0, 32'hFFFFFFFE}) begin bad++; $display("FAIL sub_hold%0d got=%b%b %h exp=10 fffffffe", i, resp_valid, req_ready, z_lo); end
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        total++; if ({req_ready, resp_valid, alu_ctrl} !== {1'b1, 1'b0, 15'h0}) begin bad++; $display("FAIL sub_no_accept_at_hs got=%b%b %h exp=10 0000", req_ready, resp_valid, alu_ctrl); end
        req_valid = 1'b0; resp_ready = 1'b0;
        @(posedge clock); #1;
        total++; if ({req_ready, z_lo} !== {1'b1, 32'hFFFFFFFE}) begin bad++; $display("FAIL sub_idle_after got=%b %h exp=1 fffffffe", req_ready, z_lo); end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [14:0] c; logic oh;
        req_valid = 1'b1; req_op = 5'b01111; req_a = 32'd17; req_b = 32'd0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        total++; if ({alu_ctrl, div_by_zero} !== {15'h0008, 1'b1}) begin bad++; $display("FAIL midrst_exec got=%h %b exp=0008 1", alu_ctrl, div_by_zero); end
        clear_n = 1'b0; #1;
        total++; if ({req_ready, resp_valid, div_by_zero, alu_ctrl, alu_a} !== {3'b100, 15'h0, 32'h0}) begin bad++; $display("FAIL midrst_outputs got=%b%b%b %h %h exp=100 0000 0", req_ready, resp_valid, div_by_zero, alu_ctrl, alu_a); end
        total++; if ({z_hi, z_lo} !== 64'h0) begin bad++; $display("FAIL midrst_z got=%h_%h exp=0", z_hi, z_lo); end
        #2 clear_n = 1'b1;
        @(posedge clock); #1;
        issue(5'b00011, 32'd1, 32'd1, lat, c, oh);
        total++; if ({lat, z_lo} !== {32'd1, 32'd2}) begin bad++; $display("FAIL midrst_add got lat=%0d z_lo=%h exp=1 2", lat, z_lo); end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_illegal();
        int lat; logic [14:0] c; logic oh;
        issue(5'b11111, 32'h1234_5678, 32'h9ABC_DEF0, lat, c, oh);
        total++; if (lat !== 1) begin bad++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
        total++; if (c !== 15'h0) begin bad++; $display("FAIL illegal_ctrl got=%h exp=0", c); end
        total++; if ({illegal_op, z_hi, z_lo} !== {1'b1, 64'h0}) begin bad++; $display("FAIL illegal_result got=%b %h_%h exp=1 0_0", illegal_op, z_hi, z_lo); end
        resp_ready = 1'b1; #1;
        total++; if ({hi_we, lo_we} !== 2'b00) begin bad++; $display("FAIL illegal_we got=%b exp=00", {hi_we, lo_we}); end
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ops  [13] = '{5'b01100, 5'b01101, 5'b01110, 5'b00111, 5'b01000, 5'b01001, 5'b01010,
                                   5'b01011, 5'b00101, 5'b00110, 5'b10001, 5'b10010, 5'b00100};
        logic [14:0] ctrl [13] = '{15'h0001, 15'h0200, 15'h0400, 15'h0080, 15'h0100, 15'h0010, 15'h0020,
                                   15'h0040, 15'h0200, 15'h0400, 15'h0800, 15'h1000, 15'h0002};
        logic [31:0] zlo  [13] = '{32'h800000F5, 32'h00000000, 32'h800000F5, 32'h1800000F, 32'h00000F18,
                                   32'h0800000F, 32'hF800000F, 32'h00000F10, 32'h00000000, 32'h800000F5,
                                   32'h7FFFFF0F, 32'h7FFFFF0E, 32'h800000ED};
        int lat; logic [14:0] c; logic oh;
        resp_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            issue(ops[i], 32'h800000F1, 32'h00000004, lat, c, oh);
            total++; if ({lat, c, oh, illegal_op} !== {32'd1, ctrl[i], 1'b1, 1'b0}) begin bad++; $display("FAIL b2b_ctrl%0d got lat=%0d ctrl=%h oh=%b ill=%b exp=1 %h 1 0", i, lat, c, oh, illegal_op, ctrl[i]); end
            total++; if ({z_hi, z_lo} !== {32'd0, zlo[i]}) begin bad++; $display("FAIL b2b_z%0d got=%h_%h exp=0_%h", i, z_hi, z_lo, zlo[i]); end
            @(posedge clock); #1;
        end
        resp_ready = 1'b0;
        total++; if ({req_ready, resp_valid, alu_ctrl} !== {2'b10, 15'h0}) begin bad++; $display("FAIL b2b_end got=%b%b %h exp=10 0000", req_ready, resp_valid, alu_ctrl); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_op();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
